// File: rtl/mul_red_sched_pkg.sv
// Shared types and helpers for the mul_red issue scheduler.
// The tag id field is sized for up to 256 requesters; the top zero-extends its id into it.
package mul_red_sched_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CFG   = 2'd2
    } state_t;

    localparam int TAG_ID_W = 8;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int lat(input int dm);
        return 3 * dm + 1;
    endfunction

endpackage

// File: rtl/mul_red_sched_rr_arb.sv
// Round-robin arbiter: grants the first eligible requester at or after ptr.
// ptr moves to one past the winner when adv_i is set; otherwise it holds.
module rr_arb
    import mul_red_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] elig_i,
    input  logic            adv_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_id_o,
    output logic            gnt_vld_o
);

    logic [IDW-1:0] ptr_q, ptr_d;

    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_vld_o = 1'b0;
        // First pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1.
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_vld_o && elig_i[i] && (i >= int'(ptr_q))) begin
                gnt_vld_o = 1'b1;
                gnt_o[i]  = 1'b1;
                gnt_id_o  = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_vld_o && elig_i[i] && (i < int'(ptr_q))) begin
                gnt_vld_o = 1'b1;
                gnt_o[i]  = 1'b1;
                gnt_id_o  = IDW'(i);
            end
        end
        ptr_d = ptr_q;
        if (adv_i && gnt_vld_o) begin
            ptr_d = (gnt_id_o == IDW'(NREQ - 1)) ? '0 : gnt_id_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mul_red_sched.sv
// Shares one pipelined mul_red among NREQ requesters and routes results back by tag.
// Owns q/r and swaps them only once the pipeline has drained.
//   state | meaning
//   RUN   | normal issue, one grant per cycle at most
//   DRAIN | no grants, wait for every in-flight tag to retire
//   CFG   | load q/r from cfg inputs, pulse cfg_done_o, back to RUN
module mul_red_sched
    import mul_red_sched_pkg::*;
#(
    parameter int LOGQ    = 17,
    parameter int DM      = 5,
    parameter int NREQ    = 4,
    parameter int MAX_OUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*LOGQ-1:0] req_a_i,
    input  logic [NREQ*LOGQ-1:0] req_b_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [LOGQ-1:0]      rsp_data_o,
    input  logic                 cfg_we_i,
    input  logic [LOGQ-1:0]      cfg_q_i,
    input  logic [LOGQ:0]        cfg_r_i,
    output logic                 cfg_done_o,
    output logic                 busy_o,
    output logic [LOGQ-1:0]      mr_a_o,
    output logic [LOGQ-1:0]      mr_b_o,
    output logic [LOGQ-1:0]      mr_q_o,
    output logic [LOGQ:0]        mr_r_o,
    input  logic [LOGQ-1:0]      mr_out_i
);

    localparam int LAT = lat(DM);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAX_OUT + 1);

    state_t          state_q, state_d;
    logic            cfg_done_q, cfg_done_d;
    logic [LOGQ-1:0] q_reg_q, q_reg_d;
    logic [LOGQ:0]   r_reg_q, r_reg_d;
    tag_t            tag_q [LAT];
    tag_t            tag_d [LAT];
    logic [CW-1:0]   cnt_q [NREQ];
    logic [CW-1:0]   cnt_d [NREQ];

    logic [NREQ-1:0] elig, gnt, rsp_vld;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_vld, inflight;

    rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .elig_i    (elig),
        .adv_i     (1'b1),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_vld_o (gnt_vld)
    );

    always_comb begin
        elig     = '0;
        rsp_vld  = '0;
        mr_a_o   = '0;
        mr_b_o   = '0;
        inflight = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i]    = req_valid_i[i] && (state_q == RUN) && (cnt_q[i] < CW'(MAX_OUT));
            rsp_vld[i] = tag_q[LAT-1].vld && (tag_q[LAT-1].id == TAG_ID_W'(i));
            if (gnt[i]) begin
                mr_a_o = req_a_i[i*LOGQ +: LOGQ];
                mr_b_o = req_b_i[i*LOGQ +: LOGQ];
            end
        end
        for (int k = 0; k < LAT; k++) inflight = inflight | tag_q[k].vld;

        tag_d[0].vld = gnt_vld;
        tag_d[0].id  = TAG_ID_W'(gnt_id);
        for (int k = 1; k < LAT; k++) tag_d[k] = tag_q[k-1];

        for (int i = 0; i < NREQ; i++) begin
            case ({gnt[i], rsp_vld[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
                2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        cfg_done_d = 1'b0;
        q_reg_d    = q_reg_q;
        r_reg_d    = r_reg_q;
        case (state_q)
            RUN:   if (cfg_we_i) state_d = DRAIN;
            DRAIN: if (!inflight) begin
                state_d    = CFG;
                cfg_done_d = 1'b1;
            end
            CFG: begin
                q_reg_d = cfg_q_i;
                r_reg_d = cfg_r_i;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            cfg_done_q <= 1'b0;
            q_reg_q    <= '0;
            r_reg_q    <= '0;
            for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cfg_done_q <= cfg_done_d;
            q_reg_q    <= q_reg_d;
            r_reg_q    <= r_reg_d;
            for (int k = 0; k < LAT; k++) tag_q[k] <= tag_d[k];
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign req_ready_o = gnt;
    assign rsp_valid_o = rsp_vld;
    assign rsp_data_o  = mr_out_i;
    assign cfg_done_o  = cfg_done_q;
    assign busy_o      = inflight || (state_q != RUN);
    assign mr_q_o      = q_reg_q;
    assign mr_r_o      = r_reg_q;

endmodule

// File: tb/tb_mul_red_sched.sv
// Directed bench for mul_red_sched with a behavioural 16-stage modular-multiply pipeline.
module tb_mul_red_sched;

    localparam int LOGQ = 17, DM = 5, NREQ = 4, MAX_OUT = 8, LAT = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*LOGQ-1:0] req_a = '0, req_b = '0;
    logic [NREQ-1:0]      req_ready, rsp_valid;
    logic [LOGQ-1:0]      rsp_data;
    logic                 cfg_we = 1'b0;
    logic [LOGQ-1:0]      cfg_q = '0;
    logic [LOGQ:0]        cfg_r = '0;
    logic                 cfg_done, busy;
    logic [LOGQ-1:0]      mr_a, mr_b, mr_q, mr_out;
    logic [LOGQ:0]        mr_r;
    logic [LOGQ-1:0]      pipe [LAT];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mul_red_sched #(.LOGQ(LOGQ), .DM(DM), .NREQ(NREQ), .MAX_OUT(MAX_OUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .cfg_we_i    (cfg_we),
        .cfg_q_i     (cfg_q),
        .cfg_r_i     (cfg_r),
        .cfg_done_o  (cfg_done),
        .busy_o      (busy),
        .mr_a_o      (mr_a),
        .mr_b_o      (mr_b),
        .mr_q_o      (mr_q),
        .mr_r_o      (mr_r),
        .mr_out_i    (mr_out)
    );

    // Reference mul_red: result of the operands seen at an edge appears LAT cycles later.
    always @(posedge clk) begin
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        if (mr_q == '0) pipe[0] <= '0;
        else            pipe[0] <= LOGQ'((longint'(mr_a) * longint'(mr_b)) % longint'(mr_q));
    end
    assign mr_out = pipe[LAT-1];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        req_a[i*LOGQ +: LOGQ] = LOGQ'(a);
        req_b[i*LOGQ +: LOGQ] = LOGQ'(b);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        settle;
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp: got %b want 0000", rsp_valid); else n_pass++;
        n_checks++; if (cfg_done !== 1'b0) $display("FAIL reset_cfg_done: got %b want 0", cfg_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (mr_q !== '0) $display("FAIL reset_q: got %0d want 0", mr_q); else n_pass++;
        n_checks++; if (mr_r !== '0) $display("FAIL reset_r: got %0d want 0", mr_r); else n_pass++;
        n_checks++; if (mr_a !== '0) $display("FAIL reset_mr_a: got %0d want 0", mr_a); else n_pass++;
        tick;
        rst = 1'b0;
    endtask

    // Empty pipeline: cfg_done lands two cycles after cfg_we rises.
    task automatic test_config(input int q, input int r);
        int done_k = -1;
        int pulses = 0;
        tick;
        cfg_we = 1'b1;
        cfg_q  = LOGQ'(q);
        cfg_r  = (LOGQ+1)'(r);
        settle;
        for (int k = 1; k <= 30; k++) begin
            tick;
            if (done_k >= 0) cfg_we = 1'b0;
            settle;
            if (k == 1) begin
                n_checks++; if (busy !== 1'b1) $display("FAIL cfg_busy_drain: got %b want 1", busy); else n_pass++;
            end
            if (cfg_done === 1'b1) begin
                pulses++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0 && k >= done_k + 4) break;
        end
        cfg_we = 1'b0;
        n_checks++; if (done_k != 2) $display("FAIL cfg_done_delay: got %0d want 2", done_k); else n_pass++;
        n_checks++; if (pulses != 1) $display("FAIL cfg_done_pulses: got %0d want 1", pulses); else n_pass++;
        n_checks++; if (mr_q !== LOGQ'(q)) $display("FAIL cfg_q: got %0d want %0d", mr_q, q); else n_pass++;
        n_checks++; if (mr_r !== (LOGQ+1)'(r)) $display("FAIL cfg_r: got %0d want %0d", mr_r, r); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL cfg_busy_after: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_single_op;
        int first = -1;
        logic [NREQ-1:0] seen = '0;
        logic [LOGQ-1:0] data = '0;
        tick;
        req_valid = 4'b0001;
        set_ops(0, 100, 200);
        settle;
        n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_grant: got %b want 0001", req_ready); else n_pass++;
        n_checks++; if (mr_a !== 17'd100 || mr_b !== 17'd200) $display("FAIL single_operands: got %0d,%0d want 100,200", mr_a, mr_b); else n_pass++;
        n_checks++; if (mr_r !== 18'd8736) $display("FAIL single_r: got %0d want 8736", mr_r); else n_pass++;
        for (int k = 1; k <= 24; k++) begin
            tick;
            req_valid = '0;
            settle;
            if (k == 1) begin
                n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
            end
            if (rsp_valid !== 4'b0000 && first < 0) begin
                first = k;
                seen  = rsp_valid;
                data  = rsp_data;
            end
        end
        n_checks++; if (first != 16) $display("FAIL single_latency: got %0d want 16", first); else n_pass++;
        n_checks++; if (seen !== 4'b0001) $display("FAIL single_rsp_id: got %b want 0001", seen); else n_pass++;
        n_checks++; if (data !== 17'd4638) $display("FAIL single_data: got %0d want 4638", data); else n_pass++;
    endtask

    // ptr sits at 1 after the single op, so grants run 1,2,3,0,...
    task automatic test_fairness;
        int exp_id [64];
        bit exp_v  [64];
        int exp_d  [64];
        int g;
        for (int k = 0; k < 64; k++) begin
            exp_id[k] = 0; exp_v[k] = 1'b0; exp_d[k] = 0;
        end
        for (int i = 0; i < NREQ; i++) set_ops(i, 10 + 7*i, 1000 + 3*i);
        for (int c = 0; c < 40; c++) begin
            tick;
            req_valid = (c < 12) ? 4'b1111 : 4'b0000;
            settle;
            if (c < 12) begin
                g = (1 + c) % 4;
                n_checks++; if (req_ready !== 4'(1 << g)) $display("FAIL fair_grant c=%0d: got %b want %b", c, req_ready, 4'(1 << g)); else n_pass++;
                exp_v[c+16]  = 1'b1;
                exp_id[c+16] = g;
                exp_d[c+16]  = ((10 + 7*g) * (1000 + 3*g)) % 7681;
            end
            n_checks++;
            if (rsp_valid !== (exp_v[c] ? 4'(1 << exp_id[c]) : 4'b0000))
                $display("FAIL fair_rsp c=%0d: got %b want %b", c, rsp_valid, exp_v[c] ? 4'(1 << exp_id[c]) : 4'b0000);
            else n_pass++;
            if (exp_v[c]) begin
                n_checks++; if (rsp_data !== LOGQ'(exp_d[c])) $display("FAIL fair_data c=%0d: got %0d want %0d", c, rsp_data, exp_d[c]); else n_pass++;
            end
        end
    endtask

    // 8 grants, stall, then unlock one cycle after each response (registered count).
    task automatic test_outstanding;
        bit exp_g, exp_r;
        bit drained = 1'b0;
        set_ops(2, 123, 456);
        for (int c = 0; c <= 24; c++) begin
            tick;
            req_valid = 4'b0100;
            settle;
            exp_g = (c < 8) || (c >= 17);
            exp_r = (c >= 16) && (c <= 23);
            n_checks++; if (req_ready !== (exp_g ? 4'b0100 : 4'b0000)) $display("FAIL out_grant c=%0d: got %b want %b", c, req_ready, exp_g ? 4'b0100 : 4'b0000); else n_pass++;
            n_checks++; if (rsp_valid !== (exp_r ? 4'b0100 : 4'b0000)) $display("FAIL out_rsp c=%0d: got %b want %b", c, rsp_valid, exp_r ? 4'b0100 : 4'b0000); else n_pass++;
            if (exp_r) begin
                n_checks++; if (rsp_data !== 17'd2321) $display("FAIL out_data c=%0d: got %0d want 2321", c, rsp_data); else n_pass++;
            end
        end
        for (int k = 0; k < 60; k++) begin
            tick;
            req_valid = '0;
            settle;
            if (!busy) begin drained = 1'b1; break; end
        end
        n_checks++; if (!drained) $display("FAIL out_drain: busy still %b want 0", busy); else n_pass++;
    endtask

    // Five old-q ops in flight, cfg_we at c=5, CFG at c=22, new grant at c=23.
    task automatic test_config_drain;
        logic [NREQ-1:0] exp_rsp;
        int exp_data;
        for (int c = 0; c <= 45; c++) begin
            tick;
            req_valid = '0;
            if (c < 5) begin
                req_valid = 4'b0010;
                set_ops(1, 3000 + c, 4000);
            end
            if (c >= 6 && c <= 23) begin
                req_valid[3] = 1'b1;
                set_ops(3, 5000, 7000);
            end
            cfg_we = (c >= 5 && c <= 22);
            cfg_q  = 17'd12289;
            cfg_r  = 18'd21843;
            settle;
            if (c < 5) begin
                n_checks++; if (req_ready !== 4'b0010) $display("FAIL drain_old_grant c=%0d: got %b want 0010", c, req_ready); else n_pass++;
            end else if (c >= 6 && c <= 22) begin
                n_checks++; if (req_ready !== 4'b0000) $display("FAIL drain_no_grant c=%0d: got %b want 0000", c, req_ready); else n_pass++;
            end else if (c == 23) begin
                n_checks++; if (req_ready !== 4'b1000) $display("FAIL drain_new_grant: got %b want 1000", req_ready); else n_pass++;
            end
            exp_rsp  = 4'b0000;
            exp_data = 0;
            if (c >= 16 && c <= 20) begin
                exp_rsp  = 4'b0010;
                exp_data = ((3000 + c - 16) * 4000) % 7681;
            end
            if (c == 39) begin
                exp_rsp  = 4'b1000;
                exp_data = 928;
            end
            n_checks++; if (rsp_valid !== exp_rsp) $display("FAIL drain_rsp c=%0d: got %b want %b", c, rsp_valid, exp_rsp); else n_pass++;
            if (exp_rsp != 4'b0000) begin
                n_checks++; if (rsp_data !== LOGQ'(exp_data)) $display("FAIL drain_data c=%0d: got %0d want %0d", c, rsp_data, exp_data); else n_pass++;
            end
            n_checks++; if (cfg_done !== (c == 22)) $display("FAIL drain_cfg_done c=%0d: got %b want %b", c, cfg_done, (c == 22)); else n_pass++;
        end
        cfg_we = 1'b0;
    endtask

    // Ten grants leave ptr at 2; reset must clear tags, counters and ptr.
    task automatic test_reset_midflight;
        for (int i = 0; i < NREQ; i++) set_ops(i, 50 + i, 60 + i);
        for (int c = 0; c < 10; c++) begin
            tick;
            req_valid = 4'b1111;
            settle;
            n_checks++; if (req_ready !== 4'(1 << (c % 4))) $display("FAIL rmf_grant c=%0d: got %b want %b", c, req_ready, 4'(1 << (c % 4))); else n_pass++;
        end
        tick;
        req_valid = '0;
        rst = 1'b1;
        settle;
        for (int c = 11; c <= 26; c++) begin
            tick;
            rst = 1'b0;
            settle;
            n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL rmf_rsp c=%0d: got %b want 0000", c, rsp_valid); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL rmf_busy c=%0d: got %b want 0", c, busy); else n_pass++;
        end
        tick;
        req_valid = 4'b1111;
        settle;
        n_checks++; if (req_ready !== 4'b0001) $display("FAIL rmf_ptr: got %b want 0001", req_ready); else n_pass++;
        tick;
        req_valid = '0;
    endtask

    initial begin
        test_reset;
        test_config(7681, 8736);
        test_single_op;
        test_fairness;
        test_outstanding;
        test_config_drain;
        test_reset_midflight;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_red_sched.md
# mul_red_sched

Scheduler that shares one fully pipelined `mul_red` modular multiply-reduce unit among `NREQ` requesters inside the NTT ALU. It arbitrates round-robin, issues at most one operation per cycle, and tracks the requester id of every in-flight operation. Each result is routed back to its originator. It also owns the modulus `q` and Barrett constant `r`, and sequences their updates by draining the pipeline first.

## Interface
- `LOGQ`, 17, operand/modulus width.
- `DM`, 5, `int_mult` latency. Pipeline latency is `LAT = 3*DM+1` (16 at defaults).
- `NREQ`, 4, number of requesters (≥2).
- `MAX_OUT`, 8, maximum in-flight operations per requester.
- Ports:
  - `clk` in 1: sole clock.
  - `rst` in 1: synchronous, active-high reset.
  - `req_valid_i` in `NREQ`: per-requester operation request.
  - `req_a_i`, `req_b_i` in `NREQ*LOGQ`: packed operands; requester `i` occupies bits `[i*LOGQ +: LOGQ]`.
  - `req_ready_o` out `NREQ`: one-hot grant; the operation is accepted this cycle.
  - `rsp_valid_o` out `NREQ`: one-hot result strobe (no backpressure).
  - `rsp_data_o` out `LOGQ`: result, shared by all requesters.
  - `cfg_we_i` in 1: request a `q`/`r` update, held until `cfg_done_o`.
  - `cfg_q_i` in `LOGQ`, `cfg_r_i` in `LOGQ+1`: new constants.
  - `cfg_done_o` out 1: one-cycle pulse when the new constants are installed.
  - `busy_o` out 1: an operation is in flight or the state is not RUN.
  - `mr_a_o`, `mr_b_o` out `LOGQ`; `mr_q_o` out `LOGQ`; `mr_r_o` out `LOGQ+1`: drive `mul_red`.
  - `mr_out_i` in `LOGQ`: `mul_red` result.

## Operation
- State machine:
  - RUN: normal issue. Moves to DRAIN when `cfg_we_i`=1.
  - DRAIN: no grants. Moves to CFG when no operation is in flight.
  - CFG: one cycle. Loads `q_reg`←`cfg_q_i` and `r_reg`←`cfg_r_i`, pulses `cfg_done_o`, then returns to RUN.
- Eligibility: requester `i` is eligible iff `req_valid_i[i]`, state is RUN, and `out_cnt[i] < MAX_OUT`. `out_cnt` is the registered value; a response in the same cycle does not unlock a grant.
- Arbitration: round-robin pointer `ptr`. Grant the first eligible requester at or after `ptr` (cyclic). After a grant to `g`, `ptr` ← `(g+1) mod NREQ`. With no grant, `ptr` holds.
- `req_ready_o` is combinational from `req_valid_i`, so it may depend on valid; requesters must not make valid depend on ready.
- Issue: `mr_a_o`/`mr_b_o` carry the granted requester's operands, or 0 when nothing is granted. `mr_q_o`=`q_reg` and `mr_r_o`=`r_reg` at all times.
- Tag pipe: a `LAT`-deep shift register of `{vld, id[$clog2(NREQ)]}`. Stage 0 is loaded with the grant each cycle (`vld`=0 if none).
- Response: when tail `vld`=1, `rsp_valid_o[id]`=1. `rsp_data_o`=`mr_out_i` as a combinational pass-through.
- Counters, per requester: +1 on grant, −1 on response, unchanged if both occur in the same cycle. A counter never exceeds `MAX_OUT` and never underflows.
- `busy_o` = (any tag `vld`) OR (state ≠ RUN).

## Timing
- Reset values:
  - state RUN, `ptr`=0, all tags invalid, `out_cnt`=0, `q_reg`=0, `r_reg`=0.
  - Outputs: `req_ready_o`=0 unless granting in RUN; `rsp_valid_o`=0; `cfg_done_o`=0; `busy_o`=0.
- Throughput: one operation per cycle total. Back-to-back grants to the same requester are allowed when it is the only one eligible.
- Latency: an operation granted in cycle t responds in cycle t+LAT exactly.
- Config latency:
  - `cfg_we_i` rising in cycle t with an empty pipeline: DRAIN at t+1, CFG at t+2, `cfg_done_o` at t+2, first grant under the new `q`/`r` at t+3.
  - With operations in flight: the last response arrives before CFG.
- All operations in flight when DRAIN begins complete with the old `q`/`r`.
- `cfg_we_i` asserted while already in DRAIN/CFG has no extra effect. `cfg_we_i` deasserting during DRAIN still completes the update with the current `cfg_q_i`/`cfg_r_i` sampled in CFG.
- Reset mid-operation: tags and counters are cleared. Stale `mr_out_i` values produce no `rsp_valid_o`.

## Structure
- Package `mul_red_sched_pkg`: state enum `{RUN, DRAIN, CFG}`, tag struct `{vld, id}`, function `lat(dm)=3*dm+1`.
- Sub-module `rr_arb`: NREQ-wide round-robin arbiter with `ptr` register, eligibility in, one-hot grant and encoded id out, advance-on-grant input.
- `mul_red` is instantiated by the parent, not by this block.

## Test plan
- Single op: after reset, config `q`=7681, `r` per the Barrett constant; req0 sends a=100, b=200. Require `rsp_valid_o`=0001 exactly 16 cycles after the grant, with data 20000 mod 7681 = 4638.
- Fairness: all 4 requesters hold valid continuously. Grants must cycle 0,1,2,3,0,…; each response lands on the correct requester 16 cycles after its grant.
- Outstanding limit: req2 alone, always valid, `MAX_OUT`=8. Require exactly 8 grants, then ready=0 until the first response. After that, one grant per cycle in steady state.
- Config drain: with 5 ops in flight, assert `cfg_we_i` with `q`=12289. Require no grants until the last old result, results computed with the old `q`, one `cfg_done_o` pulse, and the next op reduced mod 12289.
- Reset mid-flight: assert `rst` for one cycle with 10 ops in flight. Require `rsp_valid_o`=0 for the following 16 cycles, `busy_o`=0, and `ptr`=0 (req0 wins the next contention).
